caliptra_prim_flop_pipe: RTL and testbench



---
 rtl/caliptra_prim_flop_pipe_pkg.sv | 16 +
 rtl/caliptra_prim_flop_pipe_stage.sv | 55 +++++
 rtl/caliptra_prim_flop_pipe.sv | 115 +++++++++++
 tb/tb_caliptra_prim_flop_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caliptra_prim_flop_pipe_pkg.sv
// caliptra_prim_flop_pipe_pkg
//   Shared constants and helpers for the elastic pipeline register slice.
//   MaxDepth  : largest supported number of register stages.
//   cnt_width : width of the occupancy counter for a given depth.
package caliptra_prim_flop_pipe_pkg;

  localparam int unsigned MaxDepth = 16;

  // Occupancy ranges over 0..depth inclusive. A zero depth is illegal and is
  // rejected at elaboration; returning 1 keeps port ranges well formed long
  // enough for that error to be reported.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/caliptra_prim_flop_pipe_stage.sv
// caliptra_prim_flop_pipe_stage
//   One slot of the elastic pipeline: a valid bit plus a Width-bit data
//   register. The slot loads from its upstream neighbour when advance_i is
//   high; data only captures real beats so bubbles never toggle the data
//   register.
//   Ports:
//     clk_i, rst_ni  : clock, asynchronous active-low reset
//     flush_i        : synchronous flush, clears valid (and data when
//                      ClearOnFlush)
//     advance_i      : slot takes the upstream beat/bubble this cycle
//     in_valid_i     : upstream valid
//     in_data_i      : upstream data
//     valid_o        : slot holds a beat
//     data_o         : slot data
module caliptra_prim_flop_pipe_stage
  import caliptra_prim_flop_pipe_pkg::*;
#(
  parameter int unsigned       Width        = 32,
  parameter logic [Width-1:0]  ResetValue   = '0,
  parameter bit                ClearOnFlush = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             advance_i,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             r_valid;
  logic [Width-1:0] r_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= ResetValue;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      if (ClearOnFlush) begin
        r_data <= ResetValue;
      end
    end else if (advance_i) begin
      r_valid <= in_valid_i;
      if (in_valid_i) begin
        r_data <= in_data_i;
      end
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;

endmodule

// File: rtl/caliptra_prim_flop_pipe.sv
// caliptra_prim_flop_pipe
//   Elastic, stallable, flushable pipeline register of Depth stages, each
//   Width bits wide with its own valid bit. Empty slots collapse so a stalled
//   output still accepts beats until every stage is full.
//   Ports:
//     clk_i, rst_ni : clock, asynchronous active-low reset
//     flush_i       : synchronous flush, empties all stages at the next edge
//     valid_i       : upstream beat valid
//     ready_o       : pipeline accepts a beat this cycle
//     data_i        : upstream data
//     valid_o       : output stage holds a beat
//     ready_i       : downstream accepts
//     data_o        : output stage data (not gated by valid)
//     cnt_o         : number of occupied stages
module caliptra_prim_flop_pipe
  import caliptra_prim_flop_pipe_pkg::*;
#(
  parameter int unsigned       Width        = 32,
  parameter int unsigned       Depth        = 2,
  parameter logic [Width-1:0]  ResetValue   = '0,
  parameter bit                ClearOnFlush = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [Width-1:0]             data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [Width-1:0]             data_o,
  output logic [cnt_width(Depth)-1:0]  cnt_o
);

  localparam int unsigned CntW = cnt_width(Depth);

  if (Depth < 1 || Depth > MaxDepth) begin : g_depth_check
    $error("caliptra_prim_flop_pipe: Depth must be in 1..16");
  end

  logic [Depth:0]   w_advance;
  logic [Depth-1:0] w_valid;
  logic [Depth-1:0] w_in_valid;
  logic [Width-1:0] w_data    [Depth];
  logic [Width-1:0] w_in_data [Depth];
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [CntW-1:0]  r_cnt;

  // The downstream ready acts as a virtual slot past the output stage, so
  // the output stage also fills while empty even when ready_i is low. This
  // is what lets beats reach the output stage under back-pressure.
  assign w_advance[Depth] = ready_i;

  for (genvar i = 0; i < Depth; i++) begin : g_stage
    assign w_advance[i] = ~w_valid[i] | w_advance[i+1];

    if (i == 0) begin : g_head
      assign w_in_valid[i] = valid_i;
      assign w_in_data[i]  = data_i;
    end else begin : g_body
      assign w_in_valid[i] = w_valid[i-1];
      assign w_in_data[i]  = w_data[i-1];
    end

    caliptra_prim_flop_pipe_stage #(
      .Width        (Width),
      .ResetValue   (ResetValue),
      .ClearOnFlush (ClearOnFlush)
    ) u_stage (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .flush_i    (flush_i),
      .advance_i  (w_advance[i]),
      .in_valid_i (w_in_valid[i]),
      .in_data_i  (w_in_data[i]),
      .valid_o    (w_valid[i]),
      .data_o     (w_data[i])
    );
  end

  // Ready is combinational from the output back to the input on purpose.
  assign ready_o = w_advance[0] & ~flush_i;
  assign valid_o = w_valid[Depth-1] & ~flush_i;
  assign data_o  = w_data[Depth-1];

  assign w_in_xfer  = valid_i & ready_o;
  assign w_out_xfer = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_cnt <= r_cnt + CntW'(1);
    end else if (!w_in_xfer && w_out_xfer) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  assign cnt_o = r_cnt;

`ifndef SYNTHESIS
  a_hold_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=> (w_valid[Depth-1] && $stable(data_o)));

  a_cnt_popcount : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_cnt == CntW'($countones(w_valid)));

  a_no_x : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({valid_o, ready_o}));
`endif

endmodule

// File: tb/tb_caliptra_prim_flop_pipe.sv
// tb_caliptra_prim_flop_pipe
//   Two instances: A (Depth=3, Width=8, ResetValue=A5, ClearOnFlush=1) for
//   directed scenarios, B (Depth=1, ResetValue=3C, ClearOnFlush=0) for random
//   traffic. A beat-list model (ordered beats with stage positions) predicts
//   every output each cycle; literal expectations pin the model.
module tb_caliptra_prim_flop_pipe;

  typedef struct packed {
    logic [4:0]        n;     // beats held
    logic [15:0][4:0]  p;     // stage position of each beat, oldest first
    logic [15:0][7:0]  d;     // data of each beat
    logic [7:0]        last;  // value currently sitting in the output stage
  } mst_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_flush = 1'b0, a_vi = 1'b0, a_ri = 1'b0;
  logic [7:0] a_di = '0;
  logic       a_ro, a_vo;
  logic [7:0] a_do;
  logic [1:0] a_cnt;
  logic       b_flush = 1'b0, b_vi = 1'b0, b_ri = 1'b0;
  logic [7:0] b_di = '0;
  logic       b_ro, b_vo;
  logic [7:0] b_do;
  logic [0:0] b_cnt;

  int   n_checks = 0;
  int   n_fail = 0;
  logic chk_en = 1'b0;
  logic [7:0] a_got[$];
  mst_t ma, mb;

  always #5 clk = ~clk;

  caliptra_prim_flop_pipe #(
    .Width(8), .Depth(3), .ResetValue(8'hA5), .ClearOnFlush(1'b1)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .valid_i(a_vi),
    .ready_o(a_ro), .data_i(a_di), .valid_o(a_vo), .ready_i(a_ri),
    .data_o(a_do), .cnt_o(a_cnt)
  );

  caliptra_prim_flop_pipe #(
    .Width(8), .Depth(1), .ResetValue(8'h3C), .ClearOnFlush(1'b0)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .valid_i(b_vi),
    .ready_o(b_ro), .data_i(b_di), .valid_o(b_vo), .ready_i(b_ri),
    .data_o(b_do), .cnt_o(b_cnt)
  );

  // ---------------- model ----------------
  function automatic mst_t m_reset(input logic [7:0] rv);
    mst_t t;
    t = '0;
    t.last = rv;
    return t;
  endfunction

  // Which beats move one slot forward (or leave, for the oldest at the end).
  function automatic logic [15:0] m_moves(input mst_t s, input int dep, input logic r);
    logic [15:0] mv;
    mv = '0;
    for (int k = 0; k < int'(s.n); k++) begin
      if (k == 0) mv[k] = (int'(s.p[0]) == dep - 1) ? r : 1'b1;
      else        mv[k] = (int'(s.p[k-1]) > int'(s.p[k]) + 1) || mv[k-1];
    end
    return mv;
  endfunction

  function automatic logic m_ready(input mst_t s, input int dep, input logic r, input logic f);
    logic [15:0] mv;
    if (f) return 1'b0;
    if (s.n == 0) return 1'b1;
    mv = m_moves(s, dep, r);
    return (s.p[int'(s.n) - 1] != 0) || mv[int'(s.n) - 1];
  endfunction

  function automatic mst_t m_next(input mst_t s, input int dep, input logic v,
                                  input logic [7:0] din, input logic r, input logic f,
                                  input logic [7:0] rv, input logic clr);
    mst_t t;
    logic [15:0] mv;
    logic rdy;
    int np;
    t = s;
    if (f) begin
      t.n = '0;
      if (clr) t.last = rv;
      return t;
    end
    mv  = m_moves(s, dep, r);
    rdy = m_ready(s, dep, r, 1'b0);
    t.n = '0;
    for (int k = 0; k < int'(s.n); k++) begin
      if (mv[k] && int'(s.p[k]) == dep - 1) continue;
      np = int'(s.p[k]) + (mv[k] ? 1 : 0);
      t.p[int'(t.n)] = 5'(np);
      t.d[int'(t.n)] = s.d[k];
      if (mv[k] && np == dep - 1) t.last = s.d[k];
      t.n = t.n + 5'd1;
    end
    if (v && rdy) begin
      t.p[int'(t.n)] = '0;
      t.d[int'(t.n)] = din;
      if (dep == 1) t.last = din;
      t.n = t.n + 5'd1;
    end
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= m_reset(8'hA5);
      mb <= m_reset(8'h3C);
    end else begin
      ma <= m_next(ma, 3, a_vi, a_di, a_ri, a_flush, 8'hA5, 1'b1);
      mb <= m_next(mb, 1, b_vi, b_di, b_ri, b_flush, 8'h3C, 1'b0);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_ready", 32'(a_ro), 32'(m_ready(ma, 3, a_ri, a_flush)));
      check("a_valid", 32'(a_vo), 32'(!a_flush && ma.n != 0 && ma.p[0] == 5'd2));
      check("a_data",  32'(a_do), 32'(ma.last));
      check("a_cnt",   32'(a_cnt), 32'(ma.n));
      check("b_ready", 32'(b_ro), 32'(m_ready(mb, 1, b_ri, b_flush)));
      check("b_valid", 32'(b_vo), 32'(!b_flush && mb.n != 0));
      check("b_data",  32'(b_do), 32'(mb.last));
      check("b_cnt",   32'(b_cnt), 32'(mb.n));
      if (a_vo && a_ri) a_got.push_back(a_do);
    end
  end

  task automatic check_seq(input string nm, input int n, input logic [39:0] exp);
    check({nm, "_len"}, 32'(a_got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < a_got.size()) check(nm, 32'(a_got[i]), 32'(exp[8*(n-1-i) +: 8]));
    end
    a_got.delete();
  endtask

  task automatic step(input logic f, input logic v, input logic [7:0] d, input logic r);
    a_flush = f; a_vi = v; a_di = d; a_ri = r;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    // reset state
    check("rst_valid", 32'(a_vo), 32'h0);
    check("rst_cnt",   32'(a_cnt), 32'h0);
    check("rst_data",  32'(a_do), 32'hA5);
    check("rst_ready", 32'(a_ro), 32'h1);
    a_flush = 1'b1; #1;
    check("rst_ready_flush", 32'(a_ro), 32'h0);
    a_flush = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // latency / throughput, ready_i=1
    step(0, 1, 8'h01, 1);
    check("lat_cnt1", 32'(a_cnt), 32'h1);
    check("lat_v1",   32'(a_vo), 32'h0);
    step(0, 1, 8'h02, 1);
    step(0, 1, 8'h03, 1);
    check("lat_cnt3", 32'(a_cnt), 32'h3);
    check("lat_v3",   32'(a_vo), 32'h1);
    check("lat_d3",   32'(a_do), 32'h01);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    check("drain_v",  32'(a_vo), 32'h0);
    check("drain_d",  32'(a_do), 32'h03);
    check_seq("seq_t1", 3, 40'h0000010203);

    // back-pressure
    for (int i = 1; i <= 3; i++) step(0, 1, 8'(i), 0);
    check("bp_cnt",   32'(a_cnt), 32'h3);
    check("bp_ready", 32'(a_ro), 32'h0);
    check("bp_data",  32'(a_do), 32'h01);
    step(0, 1, 8'h04, 0);
    step(0, 1, 8'h04, 0);
    check("bp_hold",  32'(a_do), 32'h01);
    check("bp_cnt2",  32'(a_cnt), 32'h3);
    step(0, 1, 8'h04, 1);
    step(0, 1, 8'h05, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);
    check_seq("seq_t2", 5, 40'h0102030405);

    // bubble collapse
    step(0, 1, 8'h11, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    check("bub_cnt1", 32'(a_cnt), 32'h1);
    check("bub_v",    32'(a_vo), 32'h1);
    step(0, 1, 8'h22, 0);
    check("bub_cnt2", 32'(a_cnt), 32'h2);
    check("bub_rdy2", 32'(a_ro), 32'h1);
    step(0, 1, 8'h33, 0);
    check("bub_cnt3", 32'(a_cnt), 32'h3);
    check("bub_rdy3", 32'(a_ro), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);
    check_seq("seq_t3", 3, 40'h0000112233);

    // flush with ClearOnFlush=1
    step(0, 1, 8'h44, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h55, 0);
    check("fl_pre_cnt", 32'(a_cnt), 32'h2);
    check("fl_pre_v",   32'(a_vo), 32'h1);
    a_flush = 1'b1; a_vi = 1'b1; a_di = 8'h66; a_ri = 1'b1; #1;
    check("fl_ready", 32'(a_ro), 32'h0);
    check("fl_valid", 32'(a_vo), 32'h0);
    @(posedge clk); #1;
    a_flush = 1'b0; a_vi = 1'b0; #1;
    check("fl_cnt",  32'(a_cnt), 32'h0);
    check("fl_data", 32'(a_do), 32'hA5);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    check("fl_post_v", 32'(a_vo), 32'h0);
    check_seq("seq_t4", 0, 40'h0);

    // asynchronous reset mid-stream
    step(0, 1, 8'h77, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h88, 0);
    check("ar_pre_cnt", 32'(a_cnt), 32'h2);
    a_vi = 1'b0;
    rst_n = 1'b0; #1;
    check("ar_valid", 32'(a_vo), 32'h0);
    check("ar_cnt",   32'(a_cnt), 32'h0);
    check("ar_data",  32'(a_do), 32'hA5);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'h02, 1);
    step(0, 1, 8'h03, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);
    check_seq("seq_t5", 3, 40'h0000010203);

    // Depth=1 instance: directed pins, then random traffic
    check("b_rst_data", 32'(b_do), 32'h3C);
    b_vi = 1'b1; b_di = 8'h5A; b_ri = 1'b0; #1;
    check("b_empty_ready", 32'(b_ro), 32'h1);
    @(posedge clk); #1;
    check("b_full_v",     32'(b_vo), 32'h1);
    check("b_full_d",     32'(b_do), 32'h5A);
    check("b_full_ready", 32'(b_ro), 32'h0);
    b_vi = 1'b0; b_flush = 1'b1;
    @(posedge clk); #1;
    b_flush = 1'b0; #1;
    check("b_fl_v",   32'(b_vo), 32'h0);
    check("b_fl_cnt", 32'(b_cnt), 32'h0);
    check("b_fl_d",   32'(b_do), 32'h5A);
    for (int i = 0; i < 10000; i++) begin
      b_flush = ($urandom_range(0, 31) == 0);
      b_vi    = 1'($urandom_range(0, 1));
      b_ri    = 1'($urandom_range(0, 1));
      b_di    = 8'($urandom);
      @(posedge clk); #1;
    end
    b_vi = 1'b0; b_flush = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
